// File: rtl/bus_initiator_if.sv
// Command, client data streams, arbiter handshake and shared-bus signals of bus_initiator.
// The master modport is the initiator's view; slave is the client/bus side.
interface bus_initiator_if;
   logic        cmdValid;
   logic        cmdReady;
   logic        cmdReadNotWrite;
   logic [31:0] cmdAddress;
   logic [3:0]  cmdByteEnables;
   logic [7:0]  cmdBurstSize;

   logic [31:0] wrData;
   logic        wrValid;
   logic        wrReady;
   logic [31:0] rdData;
   logic        rdValid;
   logic        rdReady;
   logic        done;
   logic        error;

   logic        busRequest;
   logic        busGrant;

   logic        endTransactionIn;
   logic        dataValidIn;
   logic        busErrorIn;
   logic        busyIn;
   logic [31:0] addressDataIn;

   logic        beginTransactionOut;
   logic        endTransactionOut;
   logic        readNotWriteOut;
   logic        dataValidOut;
   logic        busyOut;
   logic [3:0]  byteEnablesOut;
   logic [7:0]  burstSizeOut;
   logic [31:0] addressDataOut;

   modport master (
      input  cmdValid, cmdReadNotWrite, cmdAddress, cmdByteEnables, cmdBurstSize,
      input  wrData, wrValid, rdReady, busGrant,
      input  endTransactionIn, dataValidIn, busErrorIn, busyIn, addressDataIn,
      output cmdReady, wrReady, rdData, rdValid, done, error, busRequest,
      output beginTransactionOut, endTransactionOut, readNotWriteOut, dataValidOut,
      output busyOut, byteEnablesOut, burstSizeOut, addressDataOut
   );

   modport slave (
      output cmdValid, cmdReadNotWrite, cmdAddress, cmdByteEnables, cmdBurstSize,
      output wrData, wrValid, rdReady, busGrant,
      output endTransactionIn, dataValidIn, busErrorIn, busyIn, addressDataIn,
      input  cmdReady, wrReady, rdData, rdValid, done, error, busRequest,
      input  beginTransactionOut, endTransactionOut, readNotWriteOut, dataValidOut,
      input  busyOut, byteEnablesOut, burstSizeOut, addressDataOut
   );
endinterface

// File: rtl/bus_initiator.sv
// Single-channel shared-bus initiator: one command at a time, single or burst read/write.
// Define BUS_INITIATOR_TIMEOUT_EN to abort WRITE/READ after timeoutCycles cycles without progress.
module bus_initiator #(
   parameter int timeoutCycles = 1024
) (
   input logic             clock,
   input logic             reset,
   bus_initiator_if.master bus
);

   typedef enum logic [2:0] {stIdle, stRequest, stBegin, stWrite, stRead, stEnd} stateT;

   stateT       state, nextState;
   logic        cmdRead;
   logic [31:0] cmdAddr;
   logic [3:0]  cmdBe;
   logic [7:0]  cmdBurst;
   logic [8:0]  beatCount;
   logic        beatVld_p1;
   logic [31:0] beatData_p1;
   logic        endDrive;
   logic        errFlag;

   logic [8:0]  lastBeat;
   logic        inRange;
   logic        active;
   logic        beatConsumed;
   logic        writeTake;
   logic        timeoutHit;
   logic        abort;

   assign lastBeat     = {1'b0, cmdBurst};
   assign inRange      = (beatCount <= lastBeat);
   assign active       = (state == stBegin) || (state == stWrite) || (state == stRead);
   // Read beats past the commanded length are neither counted nor forwarded.
   assign beatConsumed = ((state == stWrite) && beatVld_p1 && !bus.busyIn) ||
                         ((state == stRead) && bus.dataValidIn && bus.rdReady && inRange);
   assign writeTake    = bus.wrValid && bus.wrReady;
   assign abort        = (active && bus.busErrorIn) || timeoutHit;

`ifdef BUS_INITIATOR_TIMEOUT_EN
   localparam int TmoW = $clog2(timeoutCycles) + 1;
   localparam logic [TmoW-1:0] TmoLast = TmoW'(timeoutCycles - 1);
   logic [TmoW-1:0] tmoCount;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tmoCount <= '0;
      end else if (state == stBegin) begin
         tmoCount <= '0;
      end else if ((state == stWrite) || (state == stRead)) begin
         tmoCount <= beatConsumed ? '0 : tmoCount + TmoW'(1);
      end
   end

   assign timeoutHit = ((state == stWrite) || (state == stRead)) && !beatConsumed &&
                       (tmoCount == TmoLast);
`else
   assign timeoutHit = 1'b0;
`endif

   always_comb begin
      nextState               = state;
      bus.cmdReady            = 1'b0;
      bus.wrReady             = 1'b0;
      bus.rdValid             = 1'b0;
      bus.rdData              = '0;
      bus.done                = 1'b0;
      bus.error               = 1'b0;
      bus.busRequest          = 1'b0;
      bus.beginTransactionOut = 1'b0;
      bus.endTransactionOut   = 1'b0;
      bus.readNotWriteOut     = 1'b0;
      bus.dataValidOut        = 1'b0;
      bus.busyOut             = 1'b0;
      bus.byteEnablesOut      = '0;
      bus.burstSizeOut        = '0;
      bus.addressDataOut      = '0;
      unique case (state)
         stIdle: begin
            bus.cmdReady = 1'b1;
            if (bus.cmdValid) nextState = stRequest;
         end
         stRequest: begin
            bus.busRequest = 1'b1;
            if (bus.busGrant) nextState = stBegin;
         end
         stBegin: begin
            bus.busRequest          = 1'b1;
            bus.beginTransactionOut = 1'b1;
            bus.addressDataOut      = cmdAddr;
            bus.readNotWriteOut     = cmdRead;
            bus.byteEnablesOut      = cmdBe;
            bus.burstSizeOut        = cmdBurst;
            // First write beat is taken here so it reaches the bus right after begin.
            bus.wrReady             = !cmdRead;
            nextState               = cmdRead ? stRead : stWrite;
         end
         stWrite: begin
            bus.busRequest   = 1'b1;
            bus.wrReady      = !beatVld_p1;
            bus.dataValidOut = beatVld_p1;
            if (beatVld_p1) bus.addressDataOut = beatData_p1;
            if (beatConsumed && (beatCount == lastBeat)) nextState = stEnd;
         end
         stRead: begin
            bus.busRequest = 1'b1;
            bus.busyOut    = !bus.rdReady;
            bus.rdData     = bus.addressDataIn;
            bus.rdValid    = bus.dataValidIn && inRange;
            if (bus.endTransactionIn) nextState = stEnd;
         end
         stEnd: begin
            bus.done              = 1'b1;
            bus.error             = errFlag;
            bus.endTransactionOut = endDrive;
            nextState             = stIdle;
         end
         default: nextState = stIdle;
      endcase
      if (abort) nextState = stEnd;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= stIdle;
         beatCount  <= '0;
         beatVld_p1 <= 1'b0;
         endDrive   <= 1'b0;
         errFlag    <= 1'b0;
      end else begin
         state <= nextState;
         if ((state == stIdle) && bus.cmdValid) beatCount <= '0;
         else if (beatConsumed)                 beatCount <= beatCount + 9'd1;
         if (writeTake && (nextState == stWrite))             beatVld_p1 <= 1'b1;
         else if (beatConsumed || (nextState != stWrite))     beatVld_p1 <= 1'b0;
         // The responder closes a normal read; we close writes and every abort.
         if ((nextState == stEnd) && (state != stEnd)) begin
            endDrive <= abort || (state == stWrite);
            errFlag  <= abort;
         end
      end
   end

   always_ff @(posedge clock) begin
      if ((state == stIdle) && bus.cmdValid) begin
         cmdRead  <= bus.cmdReadNotWrite;
         cmdAddr  <= bus.cmdAddress;
         cmdBe    <= bus.cmdByteEnables;
         cmdBurst <= bus.cmdBurstSize;
      end
      if (writeTake) beatData_p1 <= bus.wrData;
   end

endmodule
